// File: rtl/booth_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_mult_seq
//   Radix-2 Booth sequential multiplier. Operands are extended by one bit
//   (sign or zero according to signed_mode) so a single signed Booth pass of
//   WIDTH+1 iterations covers both signed and unsigned multiplies.
//
// Ports
//   clock        rising-edge clock
//   resetn       asynchronous active-low reset
//   start        start request, honoured only in IDLE
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with start)
//   multiplicand M operand (sampled with start)
//   multiplier   Q operand (sampled with start)
//   busy         high while iterating (CHECK/SHIFT)
//   done         one-cycle pulse, coincident with a fresh product
//   product      registered 2*WIDTH result, held until the next done
// ---------------------------------------------------------------------------
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int XW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DONE} state_t;

    state_t          r_state;
    logic [XW-1:0]   r_a;
    logic [XW-1:0]   r_q;
    logic [XW-1:0]   r_m;
    logic            r_q1;
    logic [CW-1:0]   r_count;

    logic [XW-1:0]   w_m_ext;
    logic [XW-1:0]   w_q_ext;
    logic [2*XW:0]   w_sh;

    // Extra top bit makes unsigned operands look positive to signed Booth.
    assign w_m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    assign w_q_ext = {signed_mode & multiplier[WIDTH-1],   multiplier};

    // {A,Q,Q_1} shifted right arithmetically: old Q_1 falls off the bottom.
    assign w_sh = {r_a[XW-1], r_a, r_q};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_q1    <= 1'b0;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= '0;
                        r_m     <= w_m_ext;
                        r_q     <= w_q_ext;
                        r_q1    <= 1'b0;
                        r_count <= CW'(XW);
                        busy    <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    case ({r_q[0], r_q1})
                        2'b10:   r_a <= r_a - r_m;
                        2'b01:   r_a <= r_a + r_m;
                        default: ;
                    endcase
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_a     <= w_sh[2*XW:XW+1];
                    r_q     <= w_sh[XW:1];
                    r_q1    <= w_sh[0];
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        // Load the result on the edge entering DONE so product
                        // and done appear in the same cycle.
                        product <= w_sh[2*WIDTH:1];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  mc8 = '0, mp8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;
    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  mc4 = '0, mp4 = '0;
    logic        busy4, done4;
    logic [7:0]  prod4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    booth_mult_seq #(.WIDTH(8)) u8 (
        .clock(clock), .resetn(resetn), .start(start8), .signed_mode(sm8),
        .multiplicand(mc8), .multiplier(mp8),
        .busy(busy8), .done(done8), .product(prod8));

    booth_mult_seq #(.WIDTH(4)) u4 (
        .clock(clock), .resetn(resetn), .start(start4), .signed_mode(sm4),
        .multiplicand(mc4), .multiplier(mp4),
        .busy(busy4), .done(done4), .product(prod4));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer multiply, truncated to 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input bit m,
                                            input logic [7:0] a, input logic [7:0] b);
        longint sa, sb, p;
        logic [63:0] pv;
        sa = a; sb = b;
        if (m) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        p  = sa * sb;
        pv = p;
        return (w == 8) ? {16'h0, pv[15:0]} : {24'h0, pv[7:0]};
    endfunction

    // done must be a single-cycle pulse and never overlap busy.
    logic prev_done8 = 1'b0;
    always @(negedge clock) begin
        if (done8) begin
            chk("done_vs_busy", {31'h0, busy8}, 32'h0);
            chk("done_width", {31'h0, prev_done8}, 32'h0);
        end
        prev_done8 <= done8;
    end

    // Runs one operation; returns product, cycles from accept edge to done,
    // and number of busy cycles seen.
    task automatic run_op(input bit w4, input bit m, input logic [7:0] a, input logic [7:0] b,
                          output logic [31:0] p, output int lat, output int bcnt);
        int guard = 0;
        @(negedge clock);
        while ((w4 ? (busy4 | done4) : (busy8 | done8)) && guard < 100) begin
            @(negedge clock); guard++;
        end
        if (w4) begin sm4 = m; mc4 = a[3:0]; mp4 = b[3:0]; start4 = 1'b1; end
        else    begin sm8 = m; mc8 = a;      mp8 = b;      start8 = 1'b1; end
        @(posedge clock); #1;
        start4 = 1'b0; start8 = 1'b0;
        lat = 0; bcnt = 0;
        while (!(w4 ? done4 : done8) && lat < 100) begin
            if (w4 ? busy4 : busy8) bcnt++;
            @(posedge clock); #1; lat++;
        end
        if (lat >= 100) chk("done_timeout", 32'd0, 32'd1);
        p = w4 ? {24'h0, prod4} : {16'h0, prod8};
    endtask

    typedef struct {
        bit          m;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        logic [31:0] p;
        int          lat, bcnt, cyc;
        bit          saw;

        vecs[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[3] = '{1'b0, 8'h00, 8'hA5, 16'h0000};
        vecs[4] = '{1'b1, 8'h00, 8'hA5, 16'h0000};
        vecs[5] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        vecs[6] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[7] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};

        // Reset state
        #12;
        chk("rst_busy", {31'h0, busy8}, 32'h0);
        chk("rst_done", {31'h0, done8}, 32'h0);
        chk("rst_product", {16'h0, prod8}, 32'h0);
        @(negedge clock); resetn = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].m, vecs[i].a, vecs[i].b, p, lat, bcnt);
            chk($sformatf("vec%0d_product", i), p, {16'h0, vecs[i].exp});
            chk($sformatf("vec%0d_latency", i), lat, 32'd18);
            chk($sformatf("vec%0d_busy", i), bcnt, 32'd18);
        end

        // start held high; operands changed right after the accept edge
        @(negedge clock); @(negedge clock);
        sm8 = 1'b0; mc8 = 8'd3; mp8 = 8'd4; start8 = 1'b1;
        @(posedge clock); #1;
        mc8 = 8'd10; mp8 = 8'd11;
        cyc = 0;
        while (!done8 && cyc < 100) begin @(posedge clock); #1; cyc++; end
        chk("hold_first_lat", cyc, 32'd18);
        chk("hold_first_prod", {16'h0, prod8}, 32'd12);
        @(posedge clock); #1; cyc++;
        chk("hold_idle_busy", {31'h0, busy8}, 32'h0);
        @(posedge clock); #1; cyc++;
        chk("hold_second_accept", {31'h0, busy8}, 32'h1);
        chk("hold_prod_stable", {16'h0, prod8}, 32'd12);
        while (!done8 && cyc < 100) begin @(posedge clock); #1; cyc++; end
        start8 = 1'b0;
        chk("hold_second_lat", cyc, 32'd38);
        chk("hold_second_prod", {16'h0, prod8}, 32'd110);

        // Reset mid-operation
        @(negedge clock); @(negedge clock);
        sm8 = 1'b0; mc8 = 8'd7; mp8 = 8'd9; start8 = 1'b1;
        @(posedge clock); #1; start8 = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock); resetn = 1'b0; #1;
        chk("arst_busy", {31'h0, busy8}, 32'h0);
        chk("arst_done", {31'h0, done8}, 32'h0);
        chk("arst_product", {16'h0, prod8}, 32'h0);
        @(negedge clock); resetn = 1'b1;
        saw = 1'b0;
        repeat (30) begin @(negedge clock); if (done8 || busy8) saw = 1'b1; end
        chk("arst_no_done", {31'h0, saw}, 32'h0);
        run_op(1'b0, 1'b0, 8'd7, 8'd9, p, lat, bcnt);
        chk("arst_rerun", p, 32'h3F);

        // WIDTH=4 instance
        run_op(1'b1, 1'b1, 8'h08, 8'h07, p, lat, bcnt);
        chk("w4_signed_prod", p, 32'hC8);
        chk("w4_signed_lat", lat, 32'd10);
        run_op(1'b1, 1'b0, 8'h0F, 8'h0F, p, lat, bcnt);
        chk("w4_unsigned_prod", p, 32'hE1);
        for (int i = 0; i < 50; i++) begin
            logic [7:0] a, b;
            bit m;
            a = 8'($urandom_range(0, 15)); b = 8'($urandom_range(0, 15));
            m = 1'($urandom_range(0, 1));
            run_op(1'b1, m, a, b, p, lat, bcnt);
            chk("w4_rand", p, ref_mul(4, m, a, b));
        end

        // Randomised WIDTH=8 sweep
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            bit m;
            a = 8'($urandom); b = 8'($urandom);
            m = 1'($urandom_range(0, 1));
            run_op(1'b0, m, a, b, p, lat, bcnt);
            chk("rand_product", p, ref_mul(8, m, a, b));
            chk("rand_latency", lat, 32'd18);
        end

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
